seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per enabled cycle.
// Fixed latency of WIDTH+2 enabled cycles from the start-accept edge to the done pulse.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dd_reg;
  logic [WIDTH-1:0] dv_reg;
  logic [WIDTH-1:0] a_reg;   // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] r_reg;
  logic             sign_n;
  logic             sign_d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             dz_c;
  logic             ovf_c;

  // The partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so
  // one extra bit is enough to hold the shifted value and the trial difference sign.
  always_comb begin
    shifted = {r_reg, a_reg[WIDTH-1]};
    diff    = shifted - {1'b0, b_reg};
    dz_c    = (dv_reg == '0);
    ovf_c   = (dd_reg == MOST_NEG) && (dv_reg == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dd_reg    <= '0;
      dv_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      sign_n    <= 1'b0;
      sign_d    <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        // The done cycle doubles as an idle cycle so held-high start runs back to back.
        IDLE, DONE: begin
          if (start) begin
            dd_reg <= dividend;
            dv_reg <= divisor;
            sign_n <= dividend[WIDTH-1];
            sign_d <= divisor[WIDTH-1];
            busy   <= 1'b1;
            state  <= PREP;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          a_reg <= sign_n ? -dd_reg : dd_reg;
          b_reg <= sign_d ? -dv_reg : dv_reg;
          r_reg <= '0;
          cnt   <= CW'(WIDTH);
          state <= CALC;
        end
        CALC: begin
          a_reg <= {a_reg[WIDTH-2:0], ~diff[WIDTH]};
          r_reg <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dz_c) begin
            quotient  <= '1;
            remainder <= dd_reg;
          end else begin
            quotient  <= (sign_n ^ sign_d) ? -a_reg : a_reg;
            remainder <= sign_n ? -r_reg : r_reg;
          end
          dz    <= dz_c;
          ovf   <= ovf_c;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=32): directed vector table, multi-cycle corner sequences,
// and held-start random back-to-back traffic checked through an expected-result queue.
module tb_seq_divider;

  localparam int W = 32;
  localparam int N_RAND = 1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dz;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  // Each entry is {quotient, remainder, dz, ovf}.
  logic [2*W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } vec_t;

  vec_t vecs[12];

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .ovf       (ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W+1:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    int sdd;
    int sdv;
    int q;
    int r;
    sdd = dd;
    sdv = dv;
    if (dv == '0) return {{W{1'b1}}, dd, 2'b10};
    if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) return {dd, {W{1'b0}}, 2'b01};
    q = sdd / sdv;
    r = sdd % sdv;
    return {W'(q), W'(r), 2'b00};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [2*W+1:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with q=%0h r=%0h, expected no pending result",
                 quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        check("quotient",  64'(quotient),  64'(e[2*W+1:W+2]));
        check("remainder", 64'(remainder), 64'(e[W+1:2]));
        check("dz",        64'(dz),        64'(e[1]));
        check("ovf",       64'(ovf),       64'(e[0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Launches one operation and reports the edge count from accept to done (-1 if none
  // within the budget). Optional: enable stall window, start re-pulse, reset pulse.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input int stall_at, input int stall_len,
                        input int pulse_at, input int reset_at, output int lat);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    reset    = 1'b0;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_accept", 64'(busy), 64'(1));
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start  = (n == pulse_at);
      if (n == pulse_at) begin
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      reset  = (n == reset_at);
      enable = !(n > stall_at && n <= stall_at + stall_len);
      @(posedge clk);
      #1;
      if (n == reset_at) begin
        check("rst_quotient",  64'(quotient),  64'(0));
        check("rst_remainder", 64'(remainder), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_done",      64'(done),      64'(0));
        check("rst_dz",        64'(dz),        64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start  = 1'b0;
    reset  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int cnt;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    int sel;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
    vecs[1]  = '{-32'sd100,     32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'd100,       -32'sd7,       32'hFFFF_FFF2, 32'd2,         1'b0, 1'b0};
    vecs[3]  = '{-32'sd100,     -32'sd7,       32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b1};
    vecs[5]  = '{32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0};
    vecs[6]  = '{-32'sd5,       32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0};
    vecs[7]  = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 1'b0};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0,         1'b0, 1'b0};
    vecs[10] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 1'b0};
    vecs[11] = '{32'd3,         32'd100,       32'd0,         32'd3,         1'b0, 1'b0};

    // Reset with enable low: reset must still clear everything.
    reset    = 1'b1;
    enable   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient",  64'(quotient),  64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    check("reset_busy",      64'(busy),      64'(0));
    check("reset_done",      64'(done),      64'(0));
    check("reset_dz",        64'(dz),        64'(0));
    check("reset_ovf",       64'(ovf),       64'(0));
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf});
      run_op(vecs[i].dd, vecs[i].dv, 0, 0, 0, 0, lat);
      check("table_latency", 64'(lat), 64'(34));
      check("busy_after_done", 64'(busy), 64'(0));
    end

    // Start re-pulsed on cycle 10 of busy must be ignored.
    exp_q.push_back({32'd14, 32'd2, 2'b00});
    run_op(32'd100, 32'd7, 0, 0, 10, 0, lat);
    check("ignore_start_latency", 64'(lat), 64'(34));
    count_dones(40, cnt);
    check("ignore_start_no_second_done", 64'(cnt), 64'(0));

    // Reset on cycle 15 aborts with no done pulse.
    run_op(32'd200, 32'd3, 0, 0, 0, 15, lat);
    check("abort_no_done", 64'(lat >= 0), 64'(0));

    // Start accepted on the very first edge after reset deasserts.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(32'd1000, 32'd9));
    run_op(32'd1000, 32'd9, 0, 0, 0, 0, lat);
    check("post_reset_latency", 64'(lat), 64'(34));

    // Five-cycle enable stall in CALC stretches latency to 39 edges.
    exp_q.push_back({32'hFFFF_FFF2, 32'hFFFF_FFFE, 2'b00});
    run_op(-32'sd100, 32'd7, 5, 5, 0, 0, lat);
    check("stall_latency", 64'(lat), 64'(39));

    // Random signed pairs with start held high: one result every 35 cycles.
    @(negedge clk);
    dividend = 32'd1;
    divisor  = 32'd1;
    exp_q.push_back(model(dividend, divisor));
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_RAND; i++) begin
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
          lat = n;
          break;
        end
      end
      check("b2b_interval", 64'(lat), (i == 0) ? 64'(34) : 64'(35));
      if (i < N_RAND - 1) begin
        sel = $urandom_range(0, 9);
        dd  = $urandom;
        dv  = $urandom;
        case (sel)
          0: dv = '0;
          1: begin dd = 32'h8000_0000; dv = 32'hFFFF_FFFF; end
          2: begin
            dv = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) dv = -dv;
          end
          3: dd = 32'h8000_0000;
          default: ;
        endcase
        dividend = dd;
        divisor  = dv;
        exp_q.push_back(model(dd, dv));
      end else begin
        start = 1'b0;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("final_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
